// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-player reaction timer.
// Holds the round state encoding, LED patterns and the winner-index width helper.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        RUN,
        RESULT,
        REPORT
    } state_e;

    localparam logic [7:0] LED_OFF = 8'h00;
    localparam logic [7:0] LED_GO  = 8'hFF;

    // A single player still needs a one-bit Winner port.
    function automatic int winWidth(input int numPlayers);
        return (numPlayers <= 1) ? 1 : $clog2(numPlayers);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for a bus of synchronous, debounced buttons.
// A bit pulses for one cycle, one cycle after its input rises; held levels never retrigger.
module btn_edge #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= '0;
            edge_q <= '0;
        end else begin
            prev_q <= din_i;
            edge_q <= din_i & ~prev_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/reaction_timer_mp.sv
// Multi-player reaction timer: random hold-off, per-player ms timing, cheat/slow flags,
// winner selection and LCD handshake. Define REACTION_BEST_TIME_EN to keep a best-time record.
module reaction_timer_mp
    import reaction_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int TIME_W      = 10,
    parameter int MAX_TIME    = 1000,
    parameter int RAND_W      = 13,
    parameter int MIN_DELAY   = 1000
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic                             TickMS,
    input  logic                             Start,
    input  logic [NUM_PLAYERS-1:0]           Btn,
    input  logic [RAND_W-1:0]                RandomValue,
    output logic [7:0]                       LED,
    output logic [NUM_PLAYERS*TIME_W-1:0]    ReactionTime,
    output logic [NUM_PLAYERS-1:0]           Cheat,
    output logic [NUM_PLAYERS-1:0]           Slow,
    output logic [winWidth(NUM_PLAYERS)-1:0] Winner,
    output logic                             WinnerValid,
    output logic [TIME_W-1:0]                BestTime,
    output logic                             Wait,
    output logic                             LCDUpdate,
    input  logic                             LCDAck
);

    localparam int WIN_W = winWidth(NUM_PLAYERS);

    localparam logic [TIME_W-1:0] MAX_T    = TIME_W'(MAX_TIME);
    localparam logic [TIME_W-1:0] CNT_ONE  = 1;
    localparam logic [RAND_W:0]   HOLD_ONE = 1;
    localparam logic [RAND_W:0]   HOLD_MIN = (RAND_W+1)'(MIN_DELAY);

    state_e                        state_q, state_d;
    logic [RAND_W:0]               holdoff_q, holdoff_d;
    logic [TIME_W-1:0]             count_q, count_d;
    logic [NUM_PLAYERS-1:0]        cheat_q, cheat_d;
    logic [NUM_PLAYERS-1:0]        slow_q, slow_d;
    logic [NUM_PLAYERS-1:0]        done_q, done_d;
    logic [NUM_PLAYERS*TIME_W-1:0] time_q, time_d;
    logic [WIN_W-1:0]              winner_q, winner_d;
    logic                          winnerValid_q, winnerValid_d;

    logic [NUM_PLAYERS:0]          edges;
    logic                          startEdge;
    logic [NUM_PLAYERS-1:0]        btnEdge;

    logic                          candValid;
    logic [WIN_W-1:0]              candIdx;
    logic [TIME_W-1:0]             candTime;

    btn_edge #(
        .WIDTH (NUM_PLAYERS + 1)
    ) u_edge (
        .clk_i  (Clk),
        .rst_ni (Rst),
        .din_i  ({Btn, Start}),
        .edge_o (edges)
    );

    assign startEdge = edges[0];
    assign btnEdge   = edges[NUM_PLAYERS:1];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q       <= IDLE;
            holdoff_q     <= '0;
            count_q       <= '0;
            cheat_q       <= '0;
            slow_q        <= '0;
            done_q        <= '0;
            time_q        <= '0;
            winner_q      <= '0;
            winnerValid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            holdoff_q     <= holdoff_d;
            count_q       <= count_d;
            cheat_q       <= cheat_d;
            slow_q        <= slow_d;
            done_q        <= done_d;
            time_q        <= time_d;
            winner_q      <= winner_d;
            winnerValid_q <= winnerValid_d;
        end
    end

    // Fastest eligible player; strict '<' keeps the lower index on ties.
    always_comb begin
        candValid = 1'b0;
        candIdx   = '0;
        candTime  = '1;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (!cheat_q[i] && !slow_q[i] &&
                (!candValid || time_q[i*TIME_W +: TIME_W] < candTime)) begin
                candValid = 1'b1;
                candIdx   = WIN_W'(i);
                candTime  = time_q[i*TIME_W +: TIME_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        holdoff_d     = holdoff_q;
        count_d       = count_q;
        cheat_d       = cheat_q;
        slow_d        = slow_q;
        done_d        = done_q;
        time_d        = time_q;
        winner_d      = winner_q;
        winnerValid_d = winnerValid_q;

        unique case (state_q)
            IDLE: begin
                if (startEdge) begin
                    cheat_d       = '0;
                    slow_d        = '0;
                    done_d        = '0;
                    time_d        = '0;
                    winnerValid_d = 1'b0;
                    holdoff_d     = HOLD_MIN + {1'b0, RandomValue};
                    state_d       = DELAY;
                end
            end

            DELAY: begin
                cheat_d = cheat_q | btnEdge;
                if (&cheat_d) begin
                    state_d = RESULT;
                end else if (holdoff_q == '0) begin
                    count_d = '0;
                    state_d = RUN;
                end else if (TickMS) begin
                    holdoff_d = holdoff_q - HOLD_ONE;
                end
            end

            RUN: begin
                if (count_q == MAX_T) begin
                    slow_d = ~cheat_q & ~done_q;
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (slow_d[i]) begin
                            time_d[i*TIME_W +: TIME_W] = MAX_T;
                        end
                    end
                    state_d = RESULT;
                end else begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (btnEdge[i] && !cheat_q[i] && !done_q[i]) begin
                            time_d[i*TIME_W +: TIME_W] = count_q;
                            done_d[i]                  = 1'b1;
                        end
                    end
                    if (&(done_d | cheat_q)) begin
                        state_d = RESULT;
                    end
                    if (TickMS) begin
                        count_d = count_q + CNT_ONE;
                    end
                end
            end

            RESULT: begin
                winnerValid_d = candValid;
                winner_d      = candIdx;
                state_d       = REPORT;
            end

            REPORT: begin
                if (LCDAck) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef REACTION_BEST_TIME_EN
    logic [TIME_W-1:0] bestTime_q, bestTime_d;

    always_comb begin
        bestTime_d = bestTime_q;
        if (state_q == RESULT && candValid && candTime < bestTime_q) begin
            bestTime_d = candTime;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            bestTime_q <= '1;
        end else begin
            bestTime_q <= bestTime_d;
        end
    end

    assign BestTime = bestTime_q;
`else
    assign BestTime = '1;
`endif

    always_comb begin
        LED = LED_OFF;
        case (state_q)
            RUN:     LED = LED_GO;
            REPORT:  if (winnerValid_q) LED = 8'h01 << winner_q;
            default: LED = LED_OFF;
        endcase
    end

    assign ReactionTime = time_q;
    assign Cheat        = cheat_q;
    assign Slow         = slow_q;
    assign Winner       = winner_q;
    assign WinnerValid  = winnerValid_q;
    assign Wait         = (state_q == IDLE);
    assign LCDUpdate    = (state_q == REPORT);

endmodule

// File: tb/tb_reaction_timer_mp.sv
// Self-checking bench for reaction_timer_mp: directed and randomized rounds against a round-level model.
// BestTime expectations follow REACTION_BEST_TIME_EN, matching the build of the design.
module tb_reaction_timer_mp;

    localparam int NP   = 2;
    localparam int TW   = 10;
    localparam int MAXT = 1000;
    localparam int RW   = 13;
    localparam int MIND = 1000;
    localparam int WW   = 1;

    logic             Clk;
    logic             Rst;
    logic             TickMS;
    logic             Start;
    logic [NP-1:0]    Btn;
    logic [RW-1:0]    RandomValue;
    logic [7:0]       LED;
    logic [NP*TW-1:0] ReactionTime;
    logic [NP-1:0]    Cheat;
    logic [NP-1:0]    Slow;
    logic [WW-1:0]    Winner;
    logic             WinnerValid;
    logic [TW-1:0]    BestTime;
    logic             Wait;
    logic             LCDUpdate;
    logic             LCDAck;

    int checks = 0;
    int errors = 0;
    int bestModel = (1 << TW) - 1;

    reaction_timer_mp #(
        .NUM_PLAYERS (NP),
        .TIME_W      (TW),
        .MAX_TIME    (MAXT),
        .RAND_W      (RW),
        .MIN_DELAY   (MIND)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .TickMS       (TickMS),
        .Start        (Start),
        .Btn          (Btn),
        .RandomValue  (RandomValue),
        .LED          (LED),
        .ReactionTime (ReactionTime),
        .Cheat        (Cheat),
        .Slow         (Slow),
        .Winner       (Winner),
        .WinnerValid  (WinnerValid),
        .BestTime     (BestTime),
        .Wait         (Wait),
        .LCDUpdate    (LCDUpdate),
        .LCDAck       (LCDAck)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic stepTick();
        TickMS = 1'b1;
        @(negedge Clk);
        TickMS = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
    endtask

    task automatic pulseStart();
        Start = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
    endtask

    task automatic pressButtons(input logic [NP-1:0] mask);
        Btn = Btn | mask;
        @(negedge Clk);
        @(negedge Clk);
        Btn = Btn & ~mask;
        @(negedge Clk);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic checkBest(input string tag);
`ifdef REACTION_BEST_TIME_EN
        checkOutput(tag, 64'(BestTime), 64'(bestModel));
`else
        checkOutput(tag, 64'(BestTime), 64'((1 << TW) - 1));
`endif
    endtask

    // dly[i] >= 0: player i presses after that many DELAY ticks (cheat).
    // run[i]: count at which player i presses during RUN; -1 or >= MAXT means never.
    task automatic applyStimulus(input string name, input int rv, input int dly[NP], input int run[NP]);
        int            hold;
        logic [NP-1:0] cheatM;
        logic [NP-1:0] doneM;
        logic [NP-1:0] mask;
        int            expTime[NP];
        logic [NP-1:0] expCheat;
        logic [NP-1:0] expSlow;
        logic [NP*TW-1:0] expRt;
        int            minT;
        int            expWin;
        bit            expValid;

        hold        = MIND + rv;
        RandomValue = RW'(rv);
        pulseStart();
        checkOutput({name, ".waitLow"}, 64'(Wait), 64'd0);

        cheatM = '0;
        for (int t = 0; t < hold; t++) begin
            mask = '0;
            for (int i = 0; i < NP; i++) if (dly[i] == t) mask[i] = 1'b1;
            if (mask != '0) begin
                pressButtons(mask);
                cheatM = cheatM | mask;
            end
            if (&cheatM) break;
            if (t == hold - 1) checkOutput({name, ".ledBeforeGo"}, 64'(LED), 64'h00);
            stepTick();
        end

        if (!(&cheatM)) begin
            checkOutput({name, ".ledGo"}, 64'(LED), 64'hFF);
            doneM = '0;
            for (int c = 0; c <= MAXT; c++) begin
                if (c == MAXT) break;
                mask = '0;
                for (int i = 0; i < NP; i++) if (run[i] == c) mask[i] = 1'b1;
                if (mask != '0) begin
                    pressButtons(mask);
                    doneM = doneM | (mask & ~cheatM);
                end
                if (&(doneM | cheatM)) break;
                stepTick();
            end
        end
        waitCycles(3);

        // Round-level model from the rules of the game.
        expRt = '0;
        for (int i = 0; i < NP; i++) begin
            expCheat[i] = (dly[i] >= 0);
            expSlow[i]  = 1'b0;
            expTime[i]  = 0;
        end
        if (!(&expCheat)) begin
            for (int i = 0; i < NP; i++) begin
                if (!expCheat[i]) begin
                    if (run[i] >= 0 && run[i] < MAXT) begin
                        expTime[i] = run[i];
                    end else begin
                        expTime[i] = MAXT;
                        expSlow[i] = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < NP; i++) expRt[i*TW +: TW] = TW'(expTime[i]);

        minT = 1 << 30;
        for (int i = 0; i < NP; i++)
            if (!expCheat[i] && !expSlow[i] && expTime[i] < minT) minT = expTime[i];
        expValid = (minT != (1 << 30));
        expWin   = 0;
        for (int i = NP - 1; i >= 0; i--)
            if (!expCheat[i] && !expSlow[i] && expTime[i] == minT) expWin = i;
        if (expValid && minT < bestModel) bestModel = minT;

        checkOutput({name, ".cheat"}, 64'(Cheat), 64'(expCheat));
        checkOutput({name, ".slow"}, 64'(Slow), 64'(expSlow));
        checkOutput({name, ".time"}, 64'(ReactionTime), 64'(expRt));
        checkOutput({name, ".winValid"}, 64'(WinnerValid), 64'(expValid));
        if (expValid) checkOutput({name, ".winner"}, 64'(Winner), 64'(expWin));
        checkBest({name, ".best"});
        checkOutput({name, ".lcdUpdate"}, 64'(LCDUpdate), 64'd1);
        checkOutput({name, ".ledReport"}, 64'(LED), expValid ? (64'd1 << expWin) : 64'd0);

        waitCycles(5);
        checkOutput({name, ".lcdHeld"}, 64'(LCDUpdate), 64'd1);
        LCDAck = 1'b1;
        @(negedge Clk);
        LCDAck = 1'b0;
        @(negedge Clk);
        checkOutput({name, ".lcdDone"}, 64'(LCDUpdate), 64'd0);
        checkOutput({name, ".waitIdle"}, 64'(Wait), 64'd1);
        checkOutput({name, ".ledIdle"}, 64'(LED), 64'h00);
        checkOutput({name, ".timeHeld"}, 64'(ReactionTime), 64'(expRt));
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, ".led"}, 64'(LED), 64'h00);
        checkOutput({name, ".time"}, 64'(ReactionTime), 64'd0);
        checkOutput({name, ".cheat"}, 64'(Cheat), 64'd0);
        checkOutput({name, ".slow"}, 64'(Slow), 64'd0);
        checkOutput({name, ".winner"}, 64'(Winner), 64'd0);
        checkOutput({name, ".winValid"}, 64'(WinnerValid), 64'd0);
        checkOutput({name, ".lcdUpdate"}, 64'(LCDUpdate), 64'd0);
        checkOutput({name, ".wait"}, 64'(Wait), 64'd1);
        checkOutput({name, ".best"}, 64'(BestTime), 64'((1 << TW) - 1));
    endtask

    initial begin
        int dly[NP];
        int run[NP];
        int rv;
        int hold;

        Rst         = 1'b0;
        TickMS      = 1'b0;
        Start       = 1'b0;
        Btn         = '0;
        RandomValue = '0;
        LCDAck      = 1'b0;
        waitCycles(3);
        checkResetValues("reset");
        Rst = 1'b1;
        waitCycles(2);

        dly = '{-1, -1}; run = '{230, 310};
        applyStimulus("normal", 500, dly, run);

        dly = '{-1, 800}; run = '{200, 100};
        applyStimulus("cheat", 500, dly, run);

        dly = '{-1, -1}; run = '{-1, -1};
        applyStimulus("timeout", 500, dly, run);

        dly = '{-1, -1}; run = '{150, 150};
        applyStimulus("tie", 500, dly, run);

        dly = '{100, 300}; run = '{-1, -1};
        applyStimulus("doubleCheat", 500, dly, run);

        // Asynchronous reset in the middle of RUN.
        RandomValue = RW'(500);
        pulseStart();
        for (int t = 0; t < MIND + 500; t++) stepTick();
        checkOutput("midRun.ledGo", 64'(LED), 64'hFF);
        for (int c = 0; c < 400; c++) stepTick();
        #2;
        Rst = 1'b0;
        #1;
        checkResetValues("midRun");
        bestModel = (1 << TW) - 1;
        waitCycles(2);
        Rst = 1'b1;
        waitCycles(2);
        checkOutput("midRun.waitAfter", 64'(Wait), 64'd1);

        dly = '{-1, -1}; run = '{230, 310};
        applyStimulus("afterReset", 500, dly, run);

        for (int r = 0; r < 3; r++) begin
            rv   = int'($urandom_range(0, 150));
            hold = MIND + rv;
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 3) == 0) dly[i] = int'($urandom_range(0, hold - 1));
                else dly[i] = -1;
                run[i] = int'($urandom_range(0, 1100));
            end
            applyStimulus($sformatf("random%0d", r), rv, dly, run);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reaction_timer_mp.md
Name: reaction_timer_mp

Overview:
- Parametrised multi-player successor to the single-player reaction timer core.
- Runs one round per Start press: random hold-off, then "go" on the LEDs, then per-player ms-resolution timing.
- Flags cheat (early press) and slow (timeout) per player, picks a winner and tracks the best time.
- Presents results to the LCD driver through an update/ack handshake.
- Single clock domain; ms timing comes from a one-cycle TickMS strobe, not a derived clock.

Parameters:
- NUM_PLAYERS, 2, number of player buttons (legal range 1..8).
- TIME_W, 10, width of each reaction-time field.
- MAX_TIME, 1000, timeout in ms; must be less than 2^TIME_W.
- RAND_W, 13, width of the RandomValue input.
- MIN_DELAY, 1000, fixed ms added to the random hold-off.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  asynchronous, active-low reset.
- TickMS  in  1  one-cycle strobe, once per ms.
- Start  in  1  round start button; synchronous, debounced.
- Btn  in  NUM_PLAYERS  player buttons; synchronous, debounced.
- RandomValue  in  RAND_W  free-running random value from the generator.
- LED  out  8  status LEDs.
- ReactionTime  out  NUM_PLAYERS*TIME_W  per-player times; player i at bits [i*TIME_W +: TIME_W].
- Cheat  out  NUM_PLAYERS  per-player early-press flags.
- Slow  out  NUM_PLAYERS  per-player timeout flags.
- Winner  out  WIN_W  winner index; WIN_W = max(1, clog2(NUM_PLAYERS)).
- WinnerValid  out  1  Winner is meaningful.
- BestTime  out  TIME_W  best winning time since reset.
- Wait  out  1  idle, waiting for Start.
- LCDUpdate  out  1  results ready for the display.
- LCDAck  in  1  display has consumed the results.

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE; LED=0; ReactionTime, Cheat, Slow, Winner, WinnerValid, LCDUpdate all 0; Wait=1; BestTime all ones; edge-detect history registers cleared. Reset applies from any state, including mid-round.
- Edge detection: Start and Btn are rising-edge detected internally, one cycle of latency. Level-held buttons never retrigger.
- IDLE:
  - Wait=1; LED=0; previous round's results held stable.
  - Start edge: clear Cheat, Slow, ReactionTime, WinnerValid; load hold-off = MIN_DELAY + RandomValue, sampled that cycle, register width RAND_W+1 bits; go to DELAY.
- DELAY:
  - Wait=0; LED=0; hold-off decrements on each TickMS.
  - Btn[i] edge sets Cheat[i]; that player is locked out for the rest of the round.
  - All players cheated: go straight to RESULT.
  - Hold-off reaches 0: go to RUN with the ms counter at 0.
- RUN:
  - LED=8'hFF. Counter increments on each TickMS and saturates at MAX_TIME.
  - Btn[i] edge from a player neither cheated nor done: ReactionTime[i]=counter value that cycle; mark done.
  - Simultaneous edges in one cycle: all pressing players capture the same value.
  - All non-cheat players done: go to RESULT.
  - Counter reaches MAX_TIME first: every unfinished player gets Slow[i]=1 and ReactionTime[i]=MAX_TIME; go to RESULT.
- RESULT (1 cycle):
  - Winner = lowest index among non-cheat, non-slow players with the minimum time (ties go to the lower index).
  - WinnerValid=1 if any such player exists, else 0.
  - If WinnerValid and the winning time < BestTime, BestTime is updated.
  - Go to REPORT.
- REPORT:
  - LED[NUM_PLAYERS-1:0] = one-hot of Winner when WinnerValid, else 0; upper LED bits 0.
  - LCDUpdate=1, held until LCDAck=1 is sampled; then LCDUpdate=0 and go to IDLE.
  - LCDAck outside REPORT is ignored.
- Start edges outside IDLE are ignored. Button edges in IDLE, RESULT and REPORT are ignored.

Optional Feature:
- Macro: REACTION_BEST_TIME_EN.
- Defined: BestTime register and update logic as specified above.
- Undefined: no register is built; BestTime is tied to all ones; every other output is unchanged.

Decomposition:
- Package reaction_pkg holds:
  - the state enum (IDLE, DELAY, RUN, RESULT, REPORT);
  - the WIN_W helper function;
  - the LED pattern constants (LED_OFF=8'h00, LED_GO=8'hFF).
- One sub-module, btn_edge: parametrised-width rising-edge detector with async active-low reset. One instance covers Start plus Btn.

Test Plan (NUM_PLAYERS=2, MAX_TIME=1000, MIN_DELAY=1000, RandomValue=500):
- Normal round: Start, then P0 presses 230 ticks and P1 310 ticks after LED=FF.
  - LED=FF exactly 1500 ticks after Start.
  - ReactionTime={310,230}, Winner=0, WinnerValid=1, BestTime=230.
  - LCDUpdate held until LCDAck; then LED=0 and state IDLE.
- Cheat: P1 presses at tick 800 of DELAY; P0 presses at 200 in RUN.
  - Cheat=2'b10, Winner=0, ReactionTime[0]=200.
  - Further P1 presses are ignored.
- Timeout: no presses in RUN.
  - After 1000 ticks: Slow=2'b11, both times 1000, WinnerValid=0, BestTime unchanged.
- Tie: both buttons rise in the same cycle at count 150.
  - Both times 150; Winner=0.
- Double cheat: both press during DELAY.
  - RESULT is entered without RUN; LED never FF; WinnerValid=0; LCDUpdate asserted.
- Reset mid-RUN: Rst=0 at count 400.
  - All outputs at reset values immediately (asynchronously); after release, Wait=1 and the next Start runs a normal round.
